// File: rtl/bf_result_checker_if.sv
// Memory-read and dump-stream bundle between the result checker and its
// surroundings: two combinational-read SRAM ports plus a valid/ready dump.
interface bf_result_checker_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] OMAR;
  logic [DATA_W-1:0] OMDR;
  logic [ADDR_W-1:0] EMAR;
  logic [DATA_W-1:0] EMDR;
  logic              DumpValid;
  logic              DumpReady;
  logic [ADDR_W-1:0] DumpAddr;
  logic [DATA_W-1:0] DumpData;

  // checker side: drives addresses and the dump stream
  modport master (
    output OMAR, EMAR, DumpValid, DumpAddr, DumpData,
    input  OMDR, EMDR, DumpReady
  );

  // memory / sink side
  modport slave (
    input  OMAR, EMAR, DumpValid, DumpAddr, DumpData,
    output OMDR, EMDR, DumpReady
  );
endinterface

// File: rtl/bf_result_checker.sv
// Bellman-Ford result checker: on solver completion, scans the output
// memory once, streams every word out on the dump port and, optionally,
// compares each word against an expected-result memory. A negative-cycle
// report from the solver aborts the scan and fails the run.
module bf_result_checker #(
  parameter int DEPTH    = 8192,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Finish,
  input  logic                NegCycle,
  bf_result_checker_if.master bus,
  output logic                Busy,
  output logic                Done,
  output logic                Pass,
  output logic                NegSeen,
  output logic [ADDR_W:0]     MismatchCount,
  output logic [ADDR_W-1:0]   FirstMismatchAddr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE, NEG} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              dvalid;

  // Edge detect: each solver level passes through one register (*_q); the
  // *_qq copy is the previous registered value. 'primed' makes the first
  // cycle after reset load both copies with the live level, so a level that
  // is already high when reset releases never looks like a rising edge.
  logic fin_q, fin_qq, neg_q, neg_qq, primed;
  logic fin_rise, neg_rise;

  assign fin_rise = fin_q & ~fin_qq;
  assign neg_rise = neg_q & ~neg_qq;

  // Both memories are read at the scan counter; data comes back same cycle.
  assign bus.OMAR     = cnt;
  assign bus.EMAR     = cnt;
  assign bus.DumpAddr = cnt;
  assign bus.DumpData = bus.OMDR;
  assign bus.DumpValid = dvalid;

  logic            accept;
  logic            mm;
  logic [ADDR_W:0] mc_nxt;

  assign accept = dvalid & bus.DumpReady;
  // Plain inequality: INF (all ones) therefore only matches INF.
  assign mm     = CHECK_EN && (bus.OMDR != bus.EMDR);
  assign mc_nxt = MismatchCount + (ADDR_W+1)'(mm);

  // Solver-level edge detectors.
  always_ff @(posedge clock) begin
    if (reset) begin
      fin_q  <= 1'b0;
      fin_qq <= 1'b0;
      neg_q  <= 1'b0;
      neg_qq <= 1'b0;
      primed <= 1'b0;
    end else if (!primed) begin
      fin_q  <= Finish;
      fin_qq <= Finish;
      neg_q  <= NegCycle;
      neg_qq <= NegCycle;
      primed <= 1'b1;
    end else begin
      fin_q  <= Finish;
      fin_qq <= fin_q;
      neg_q  <= NegCycle;
      neg_qq <= neg_q;
    end
  end

  // Scan FSM with registered status outputs and compare accumulators.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      dvalid            <= 1'b0;
      Busy              <= 1'b0;
      Done              <= 1'b0;
      Pass              <= 1'b0;
      NegSeen           <= 1'b0;
      MismatchCount     <= '0;
      FirstMismatchAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (neg_rise) begin
            state   <= NEG;
            Done    <= 1'b1;
            Pass    <= 1'b0;
            NegSeen <= 1'b1;
          end else if (fin_rise) begin
            state  <= SCAN;
            cnt    <= '0;
            dvalid <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        SCAN: begin
          // A negative cycle aborts the scan before this cycle's word counts.
          if (neg_rise) begin
            state   <= NEG;
            dvalid  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Pass    <= 1'b0;
            NegSeen <= 1'b1;
          end else if (accept) begin
            MismatchCount <= mc_nxt;
            if (mm && MismatchCount == '0)
              FirstMismatchAddr <= cnt;
            if (cnt == LAST) begin
              // Counter parks at the last index rather than wrapping.
              state  <= DONE;
              dvalid <= 1'b0;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Pass   <= (mc_nxt == '0);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // Terminal states hold their results until reset.
        DONE: state <= DONE;
        NEG:  state <= NEG;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bf_result_checker.md
BF_RESULT_CHECKER -- requirements
Module: bf_result_checker

Interface
REQ-001 Parameter DEPTH, default 8192, number of output-memory entries scanned (power of two, >= 2).
REQ-002 Parameter ADDR_W, default 13, address width, log2(DEPTH).
REQ-003 Parameter DATA_W, default 16, distance word width; all-ones = unreachable (INF).
REQ-004 Parameter CHECK_EN, default 1, 1 = compare against expected memory, 0 = dump only.
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 Finish  in  1  solver completion level from bellmanford.
REQ-008 NegCycle  in  1  solver negative-cycle level from bellmanford.
REQ-009 OMAR  out  ADDR_W  output-memory read address (combinational-read SRAM).
REQ-010 OMDR  in  DATA_W  output-memory read data for OMAR, same cycle.
REQ-011 EMAR  out  ADDR_W  expected-memory read address, always equal to OMAR.
REQ-012 EMDR  in  DATA_W  expected-memory read data, same cycle.
REQ-013 DumpValid  out  1  dump word valid.
REQ-014 DumpReady  in  1  downstream accepts dump word.
REQ-015 DumpAddr  out  ADDR_W  index of current dump word.
REQ-016 DumpData  out  DATA_W  current dump word (OMDR).
REQ-017 Busy  out  1  scan in progress.
REQ-018 Done  out  1  result fields valid; held until reset.
REQ-019 Pass  out  1  zero mismatches and no negative cycle.
REQ-020 NegSeen  out  1  NegCycle observed.
REQ-021 MismatchCount  out  ADDR_W+1  number of mismatching entries.
REQ-022 FirstMismatchAddr  out  ADDR_W  lowest mismatching index; 0 if none.

Function
REQ-023 States SHALL be IDLE, SCAN, DONE, NEG.
REQ-024 Finish and NegCycle SHALL be registered once; start triggers on a 0->1 transition of the registered value, not on level.
REQ-025 IDLE -> SCAN on Finish rising edge; address counter SHALL load 0 on entry.
REQ-026 IDLE or SCAN -> NEG on NegCycle rising edge; NegCycle SHALL win over simultaneous Finish.
REQ-027 In SCAN, DumpValid=1, DumpAddr=OMAR=counter, DumpData=OMDR combinationally.
REQ-028 A word is accepted on a cycle with DumpValid&DumpReady; only then SHALL counter increment and compare update.
REQ-029 Compare (CHECK_EN=1): mismatch iff OMDR != EMDR; INF equals only INF.
REQ-030 On first mismatch FirstMismatchAddr SHALL capture counter; later mismatches leave it unchanged.
REQ-031 MismatchCount increments by 1 per accepted mismatching word; max DEPTH, no wrap possible.
REQ-032 CHECK_EN=0: compare disabled, MismatchCount stays 0, EMAR still driven.
REQ-033 Acceptance at counter=DEPTH-1 -> DONE next edge; counter SHALL NOT wrap.
REQ-034 With DumpReady held high, Done SHALL assert exactly DEPTH+1 cycles after the edge that registers Finish rising.
REQ-035 DumpReady low SHALL stall with DumpAddr/DumpData stable (OMDR assumed stable).
REQ-036 DONE: Busy=0, DumpValid=0, Done=1, Pass=(MismatchCount==0); further Finish/NegCycle edges ignored.
REQ-037 NEG: Done=1, Pass=0, NegSeen=1, DumpValid=0, Busy=0; scan aborted, partial counts held.
REQ-038 Busy=1 exactly while in SCAN.

Reset
REQ-039 On reset: state IDLE, counter 0, OMAR/EMAR/DumpAddr 0, DumpValid 0, Busy 0, Done 0, Pass 0, NegSeen 0, MismatchCount 0, FirstMismatchAddr 0, edge-detect registers 0.
REQ-040 Reset SHALL override all inputs and abort SCAN/DONE/NEG in the same edge.
REQ-041 Finish held high through reset release SHALL NOT start a scan (no edge seen).

Verification
REQ-042 DEPTH=8, identical memories, DumpReady=1, Finish 0->1 -> 8 dump words addr 0..7, Done at +9 cycles, Pass=1, MismatchCount=0.
REQ-043 DEPTH=8, expected differs at 3 and 6 -> MismatchCount=2, FirstMismatchAddr=3, Pass=0.
REQ-044 OMDR=FFFF vs EMDR=FFFF at addr 0, EMDR=0005 vs OMDR=FFFF at addr 1 -> only addr 1 counted.
REQ-045 DumpReady toggling 1,0,0,1 -> DumpAddr held during stalls, no duplicate or skipped index, Done delayed by stall count.
REQ-046 NegCycle rises at scan addr 4 (and separately simultaneous with Finish) -> NEG, NegSeen=1, Pass=0, DumpValid=0 next cycle.
REQ-047 Reset asserted at addr 5 with Finish still high -> all outputs reset values, no restart until Finish falls and rises again.
